// File: rtl/seg_pkg.sv
// Shared types and segment constants for the multiplexed 7-segment driver.
// Patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h10;
  localparam seg_t SEG_A = 7'h08;
  localparam seg_t SEG_B = 7'h03;
  localparam seg_t SEG_C = 7'h46;
  localparam seg_t SEG_D = 7'h21;
  localparam seg_t SEG_E = 7'h06;
  localparam seg_t SEG_F = 7'h0E;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low segment decoder.
// Shared by all digits; the top feeds it the currently scanned nibble.
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/multi_7seg_scan.sv
// N-digit common-anode scan driver with frame-synchronous double buffering,
// guard interval, PWM brightness, blanking, decimal points and LZ blanking.
module multi_7seg_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 27_000_000,
  parameter int SLOT_HZ    = 1000,
  parameter int GUARD      = 8,
  parameter int BRIGHT_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    lzb_en_i,
  input  logic                    load_i,
  input  logic [BRIGHT_W-1:0]     bright_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int SLOT = CLK_HZ / SLOT_HZ;
  localparam int CW   = $clog2(SLOT);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int DW   = 4 * NUM_DIGITS;
  localparam int PW   = CW + BRIGHT_W + 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(SLOT - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
  localparam logic [PW-1:0] SPAN    = PW'(SLOT - GUARD);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d;
  logic                  sh_lzb_q, sh_lzb_d;
  logic                  pend_q, pend_d;
  logic [DW-1:0]         act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
  logic                  act_lzb_q, act_lzb_d;
  logic [BRIGHT_W-1:0]   bright_q, bright_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_q, frame_d;

  logic                  slot_end;
  logic                  frame_end;
  logic [NUM_DIGITS-1:0] lzb;
  logic                  seen;
  logic [3:0]            cur_nib;
  seg_t                  dec_seg;
  logic                  blank_eff;
  logic [BRIGHT_W-1:0]   br;
  logic [PW-1:0]         prod;
  logic [PW-1:0]         win_end;
  logic                  lit;

  hex_to_7seg u_dec (
    .nib_i (cur_nib),
    .seg_o (dec_seg)
  );

  assign slot_end  = (cnt_q == CNT_MAX);
  assign frame_end = slot_end && (idx_q == IDX_MAX);

  // A digit is leading-zero blanked until a nonzero, unblanked digit is seen
  always_comb begin
    seen = 1'b0;
    lzb  = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (act_dig_q[4*k +: 4] != 4'h0 && !act_blank_q[k]) begin
        seen = 1'b1;
      end
      lzb[k] = act_lzb_q && !seen;
    end
  end

  assign cur_nib   = act_dig_q[4*idx_q +: 4];
  assign blank_eff = act_blank_q[idx_q] | lzb[idx_q];

  // Duty window uses the brightness captured at slot start
  always_comb begin
    br      = (cnt_q == '0) ? bright_i : bright_q;
    prod    = (PW'(br) + PW'(1)) * SPAN;
    win_end = PW'(GUARD) + (prod >> BRIGHT_W);
    lit     = (cnt_q >= GUARD_C) && (PW'(cnt_q) < win_end);
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    bright_d = (cnt_q == '0) ? bright_i : bright_q;
  end

  // A load coinciding with the boundary stays pending for the next frame
  always_comb begin
    sh_dig_d    = sh_dig_q;
    sh_dp_d     = sh_dp_q;
    sh_blank_d  = sh_blank_q;
    sh_lzb_d    = sh_lzb_q;
    pend_d      = pend_q;
    act_dig_d   = act_dig_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    act_lzb_d   = act_lzb_q;
    if (frame_end && pend_q) begin
      act_dig_d   = sh_dig_q;
      act_dp_d    = sh_dp_q;
      act_blank_d = sh_blank_q;
      act_lzb_d   = sh_lzb_q;
      pend_d      = 1'b0;
    end
    if (load_i) begin
      sh_dig_d   = digits_i;
      sh_dp_d    = dp_i;
      sh_blank_d = blank_i;
      sh_lzb_d   = lzb_en_i;
      pend_d     = 1'b1;
    end
  end

  always_comb begin
    seg_d   = seg_q;
    dp_d    = dp_q;
    an_d    = '1;
    frame_d = frame_end;
    if (cnt_q == '0) begin
      seg_d = blank_eff ? SEG_BLANK : dec_seg;
      dp_d  = blank_eff | ~act_dp_q[idx_q];
    end
    if (lit) begin
      an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_dig_q    <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      sh_lzb_q    <= 1'b0;
      pend_q      <= 1'b0;
      act_dig_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      act_lzb_q   <= 1'b0;
      bright_q    <= '0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      an_q        <= '1;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_dig_q    <= sh_dig_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      sh_lzb_q    <= sh_lzb_d;
      pend_q      <= pend_d;
      act_dig_q   <= act_dig_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      act_lzb_q   <= act_lzb_d;
      bright_q    <= bright_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_multi_7seg_scan.sv
// Scoreboard bench for multi_7seg_scan: expected digit slots are queued per
// frame and checked by a monitor on every anode pulse.
module tb_multi_7seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic [3:0]  blank_i;
  logic        lzb_en_i;
  logic        load_i;
  logic [2:0]  bright_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_o;

  always #5 clk = ~clk;

  multi_7seg_scan #(
    .NUM_DIGITS (4),
    .CLK_HZ     (1000),
    .SLOT_HZ    (50),
    .GUARD      (2),
    .BRIGHT_W   (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .digits_i (digits_i),
    .dp_i     (dp_i),
    .blank_i  (blank_i),
    .lzb_en_i (lzb_en_i),
    .load_i   (load_i),
    .bright_i (bright_i),
    .seg_o    (seg_o),
    .dp_o     (dp_o),
    .an_o     (an_o),
    .frame_o  (frame_o)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         on;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // active-high {g..a}
  logic [6:0] hx [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                          7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                          7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] sg(input logic [3:0] n);
    logic [6:0] t;
    t = hx[n];
    return ~t;
  endfunction

  // n0..n3: nibbles, bl: effective blank, dp: lit decimal points
  task automatic push_frame(input logic [3:0] n0, input logic [3:0] n1,
                            input logic [3:0] n2, input logic [3:0] n3,
                            input logic [3:0] bl, input logic [3:0] dp,
                            input int on);
    logic [3:0] nb [4];
    exp_t e;
    nb[0] = n0; nb[1] = n1; nb[2] = n2; nb[3] = n3;
    for (int k = 0; k < 4; k++) begin
      e.an  = 4'hF;
      e.an[k] = 1'b0;
      e.seg = bl[k] ? 7'h7F : sg(nb[k]);
      e.dp  = bl[k] ? 1'b1 : ~dp[k];
      e.on  = on;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] bl, input logic lz);
    digits_i = d;
    dp_i     = dp;
    blank_i  = bl;
    lzb_en_i = lz;
    load_i   = 1'b1;
    @(negedge clk);
    load_i   = 1'b0;
  endtask

  task automatic wait_frame(input int exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_o && n < 300);
    check("frame_gap", n, exp);
  endtask

  task automatic chk_reset();
    check("rst_an", int'(an_o), 'hF);
    check("rst_seg", int'(seg_o), 'h7F);
    check("rst_dp", int'(dp_o), 1);
    check("rst_frame", int'(frame_o), 0);
  endtask

  initial begin : mon
    exp_t e;
    bit   have;
    bit   inp;
    bit   stab;
    int   len;
    logic [6:0] hs;
    logic hd;
    have = 0;
    inp  = 0;
    stab = 1;
    len  = 0;
    hs   = '0;
    hd   = 1'b0;
    forever begin
      @(negedge clk);
      if (an_o != 4'hF) begin
        if (!inp) begin
          inp  = 1;
          len  = 1;
          stab = 1;
          hs   = seg_o;
          hd   = dp_o;
          have = (sb.size() > 0);
          if (have) begin
            e = sb.pop_front();
            check("an", int'(an_o), int'(e.an));
            check("seg", int'(seg_o), int'(e.seg));
            check("dp", int'(dp_o), int'(e.dp));
          end
        end else begin
          len++;
          if (seg_o !== hs || dp_o !== hd) stab = 0;
        end
      end else if (inp) begin
        inp = 0;
        if (have) begin
          check("on_len", len, e.on);
          check("seg_stable", int'(stab), 1);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst      = 1'b1;
    digits_i = '0;
    dp_i     = '0;
    blank_i  = '0;
    lzb_en_i = 1'b0;
    load_i   = 1'b0;
    bright_i = 3'd7;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset();

    // frame 0 shows the reset data; 1234 lands on the first boundary
    do_load(16'h1234, 4'h0, 4'h0, 1'b0);
    wait_frame(79);
    push_frame(4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'h0, 18);
    wait_frame(80);
    push_frame(4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'h0, 18);
    idle(50);
    do_load(16'hABCD, 4'h0, 4'h0, 1'b0);
    wait_frame(29);
    push_frame(4'hD, 4'hC, 4'hB, 4'hA, 4'h0, 4'h0, 18);
    idle(10);
    do_load(16'h5555, 4'h0, 4'h0, 1'b0);
    idle(40);
    do_load(16'h0F0F, 4'h0, 4'h0, 1'b0);
    wait_frame(28);
    push_frame(4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 18);

    // load exactly on the boundary cycle is held for one more frame
    idle(79);
    digits_i = 16'h7777;
    load_i   = 1'b1;
    @(negedge clk);
    load_i   = 1'b0;
    check("frame_at_boundary", int'(frame_o), 1);
    push_frame(4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 18);
    wait_frame(80);
    push_frame(4'h7, 4'h7, 4'h7, 4'h7, 4'h0, 4'h0, 18);

    do_load(16'h0050, 4'h0, 4'h0, 1'b1);
    wait_frame(79);
    push_frame(4'h0, 4'h5, 4'h0, 4'h0, 4'b1100, 4'h0, 18);
    do_load(16'h0000, 4'h0, 4'h0, 1'b1);
    wait_frame(79);
    push_frame(4'h0, 4'h0, 4'h0, 4'h0, 4'b1110, 4'h0, 18);

    do_load(16'h4321, 4'h0, 4'h0, 1'b0);
    wait_frame(79);
    bright_i = 3'd0;
    push_frame(4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0, 2);
    wait_frame(80);
    bright_i = 3'd3;
    push_frame(4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h0, 9);

    do_load(16'h8E6C, 4'b0001, 4'b0100, 1'b0);
    wait_frame(79);
    bright_i = 3'd7;
    push_frame(4'hC, 4'h6, 4'hE, 4'h8, 4'b0100, 4'b0001, 18);

    // reset during digit 1 drops both the active data and a pending load
    do_load(16'h9999, 4'h0, 4'h0, 1'b0);
    wait_frame(79);
    idle(25);
    do_load(16'h5A5A, 4'h0, 4'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset();
    wait_frame(80);
    push_frame(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 18);
    wait_frame(80);
    push_frame(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 18);
    wait_frame(80);
    idle(5);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
